// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter, LSB first, fed by a valid/ready byte port.
// Ports: clk, reset (sync, active low), data/valid/ready in, busy, TXD out.
// Define UART_TX_FIFO_EN to add a FIFO_DEPTH-entry queue ahead of the FSM.
module uart_tx #(
  parameter int CLK_HZ     = 27000000,
  parameter int BAUD       = 115200,
  parameter int DIV        = CLK_HZ / BAUD,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       busy,
  output logic       TXD
);

  localparam int BW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BW-1:0] B_LAST = BW'(DIV - 1);
  localparam logic [BW-1:0] B_ONE  = BW'(1);

  if (DIV < 2 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("uart_tx: DIV must be >= 2, FIFO_DEPTH a power of two >= 2");
  end

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          txd_q, txd_d;
  logic          bit_end;
  logic          load;
  logic          avail;
  logic          can_take;
  logic          queued;
  logic [7:0]    load_byte;

  assign bit_end = (baud_q == B_LAST);

`ifdef UART_TX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] P_ONE = (AW + 1)'(1);

  logic [7:0] mem_q [FIFO_DEPTH];
  logic [AW:0] wr_q, rd_q;
  logic        empty, full, push;

  // Extra wrap bit tells full from empty when the indices match.
  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW-1:0] == rd_q[AW-1:0]) &&
                 (wr_q[AW] != rd_q[AW]);
  assign push      = valid && !full;
  assign avail     = !empty;
  assign can_take  = !full;
  assign queued    = !empty;
  assign load_byte = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_q[AW-1:0]] <= data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push) begin
        wr_q <= wr_q + P_ONE;
      end
      if (load) begin
        rd_q <= rd_q + P_ONE;
      end
    end
  end
`else
  assign avail     = valid;
  assign can_take  = (state_q == IDLE);
  assign queued    = 1'b0;
  assign load_byte = data;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    load    = 1'b0;
    if (state_q != IDLE) begin
      baud_d = bit_end ? '0 : baud_q + B_ONE;
    end
    unique case (state_q)
      IDLE: begin
        load = avail;
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
`ifdef UART_TX_FIFO_EN
          // Chain straight into the next start bit: no idle gap.
          load    = avail;
          state_d = IDLE;
`else
          state_d = IDLE;
`endif
        end
      end
    endcase
    if (load) begin
      state_d = START;
      shift_d = load_byte;
      bit_d   = '0;
      baud_d  = '0;
    end
  end

  // Line level is registered from the current state, so TXD
  // lags the state by one cycle and never glitches.
  always_comb begin
    txd_d = 1'b1;
    unique case (state_q)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_q[0];
      default: txd_d = 1'b1;
    endcase
    ready = can_take;
    busy  = (state_q != IDLE) || queued;
    TXD   = txd_q;
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx at DIV=4 and DIV=2.
// A negedge monitor decodes TXD frames and checks them against queued bytes.
module tb_uart_tx;

`ifdef UART_TX_FIFO_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] d4, d2;
  logic       v4, v2, r4, r2, b4, b2, t4, t2;

  always #5 clk = ~clk;

  uart_tx #(.DIV(4)) u4 (
    .clk(clk), .reset(rst_n), .data(d4), .valid(v4),
    .ready(r4), .busy(b4), .TXD(t4)
  );

  uart_tx #(.DIV(2)) u2 (
    .clk(clk), .reset(rst_n), .data(d2), .valid(v2),
    .ready(r2), .busy(b2), .TXD(t2)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] b;
    int         start;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
  endtask

  task automatic push_exp(input int ch, input logic [7:0] b,
                          input int st);
    exp_t e;
    e.b = b;
    e.start = st;
    if (ch == 0) sb0.push_back(e);
    else sb1.push_back(e);
  endtask

  // Monitor: sample TXD on every falling edge; a frame is 10*DIV samples.
  int         ms[2];
  int         sc[2];
  int         t0[2];
  logic [9:0] fr[2];
  logic       gl[2];

  always @(negedge clk) begin
    logic tx;
    int   dv;
    exp_t e;
    for (int ch = 0; ch < 2; ch++) begin
      tx = (ch == 0) ? t4 : t2;
      dv = (ch == 0) ? 4 : 2;
      if (rst_n !== 1'b1) begin
        ms[ch] = 0;
      end else if (ms[ch] == 0) begin
        if (tx === 1'b0) begin
          ms[ch] = 1;
          sc[ch] = 1;
          t0[ch] = cyc;
          fr[ch] = '0;
          gl[ch] = 1'b0;
        end
      end else begin
        if (sc[ch] % dv == 0) fr[ch][sc[ch] / dv] = tx;
        else if (tx !== fr[ch][sc[ch] / dv]) gl[ch] = 1'b1;
        sc[ch]++;
        if (sc[ch] == 10 * dv) begin
          ms[ch] = 0;
          if ((ch == 0 ? sb0.size() : sb1.size()) == 0) begin
            chk("frame_expected", {24'd0, fr[ch][8:1]}, 32'hFFFF_FFFF);
          end else begin
            e = (ch == 0) ? sb0.pop_front() : sb1.pop_front();
            chk("frame_byte", {24'd0, fr[ch][8:1]}, {24'd0, e.b});
            chk("stop_bit", {31'd0, fr[ch][9]}, 1);
            chk("bit_stable", {31'd0, gl[ch]}, 0);
            if (e.start >= 0) chk("start_cyc", t0[ch], e.start);
          end
        end
      end
    end
  end

  task automatic send(input int ch, input logic [7:0] b, output int acc);
    int w = 0;
    if (ch == 0) begin v4 = 1'b1; d4 = b; end
    else begin v2 = 1'b1; d2 = b; end
    acc = -1;
    while (acc < 0 && w < 200) begin
      if (((ch == 0) ? r4 : r2) === 1'b1) acc = cyc + 1;
      @(negedge clk);
      w++;
    end
    if (ch == 0) v4 = 1'b0;
    else v2 = 1'b0;
    if (acc < 0) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int a, a1, a2;
    int acc[6];
    rst_n = 1'b0;
    v4 = 1'b1; v2 = 1'b1;
    d4 = 8'hAA; d2 = 8'hAA;
    repeat (3) @(negedge clk);
    chk("rst_txd4", t4, 1);
    chk("rst_ready4", r4, 1);
    chk("rst_busy4", b4, 0);
    chk("rst_txd2", t2, 1);
    chk("rst_ready2", r2, 1);
    chk("rst_busy2", b2, 0);
    rst_n = 1'b1;
    v4 = 1'b0; v2 = 1'b0;
    @(negedge clk);
    chk("post_rst_busy4", b4, 0);
    chk("post_rst_busy2", b2, 0);
    chk("post_rst_txd4", t4, 1);

    // Single byte 0x55 at DIV=4: 40-cycle frame.
    send(0, 8'h55, a);
    push_exp(0, 8'h55, a + LAT);
    wait_cyc(a + LAT + 38);
    chk("busy_in_frame", b4, 1);
    wait_cyc(a + LAT + 39);
    chk("busy_after_frame", b4, 0);

    // Minimum divider: 0x80 at DIV=2, 20-cycle frame.
    send(1, 8'h80, a);
    push_exp(1, 8'h80, a + LAT);
    wait_cyc(a + LAT + 18);
    chk("div2_busy_in", b2, 1);
    wait_cyc(a + LAT + 19);
    chk("div2_busy_after", b2, 0);

`ifndef UART_TX_FIFO_EN
    // Backpressure: valid held, second accept one idle cycle later.
    send(0, 8'hA5, a1);
    push_exp(0, 8'hA5, a1 + 1);
    send(0, 8'h3C, a2);
    push_exp(0, 8'h3C, a2 + 1);
    chk("bp_accept_gap", a2 - a1, 41);
    wait_cyc(a2 + 40);
    chk("bp_busy_after", b4, 0);
`else
    // FIFO full: 5 accepts back to back, then ready drops.
    for (int i = 0; i < 6; i++) begin
      send(0, 8'(i + 1), acc[i]);
      push_exp(0, 8'(i + 1), acc[0] + 2 + 40 * i);
      if (i > 0 && i < 5) chk("fifo_accept_cyc", acc[i] - acc[0], i);
      if (i == 4) chk("fifo_full_ready", r4, 0);
    end
    wait_cyc(acc[0] + 241);
    chk("fifo_busy_after", b4, 0);
`endif

    // Reset during bit 3 of 0xFF aborts the frame.
    send(0, 8'hFF, a);
    push_exp(0, 8'hFF, a + LAT);
`ifdef UART_TX_FIFO_EN
    send(0, 8'h11, a1);
`endif
    wait_cyc(a + LAT + 17);
    rst_n = 1'b0;
    sb0.delete();
    @(negedge clk);
    chk("midrst_txd", t4, 1);
    chk("midrst_busy", b4, 0);
    chk("midrst_ready", r4, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_idle", b4, 0);
    send(0, 8'h00, a);
    push_exp(0, 8'h00, a + LAT);
    wait_cyc(a + LAT + 39);
    chk("after_rst_busy", b4, 0);

    repeat (5) @(negedge clk);
    chk("sb0_drained", sb0.size(), 0);
    chk("sb1_drained", sb1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

8N1 UART transmitter for the Briskv SoC. It takes bytes from the core side over a valid/ready handshake and serialises them LSB-first onto the board `TXD` pin. In the top level it is instantiated next to the clock/reset generator and replaces the constant-low `TXD` tie-off. It runs on the divided system clock `clk` and its companion reset `reset`.

## Interface

- `CLK_HZ`, default 27000000: frequency of `clk` in Hz.
- `BAUD`, default 115200: line rate in bit/s.
- `DIV`, default `CLK_HZ/BAUD` (integer truncation, 234 at defaults): clock cycles per bit. Must be ≥ 2; overridable directly.
- `FIFO_DEPTH`, default 4: entries in the transmit FIFO. Power of two. Used only with `UART_TX_FIFO_EN`.

Ports (clock and reset first):

- `clk`, in, 1: system clock. All logic samples on the rising edge.
- `reset`, in, 1: synchronous, active-low reset. 0 = reset.
- `data`, in, 8: byte to transmit.
- `valid`, in, 1: `data` is offered.
- `ready`, out, 1: block can accept a byte this cycle.
- `busy`, out, 1: a frame is in progress or bytes are queued.
- `TXD`, out, 1: serial line; idles high.

## Operation

- A transfer occurs on any rising edge where `valid && ready`. `data` is captured at that edge; `data` is don't-care otherwise.
- The FSM has four states: IDLE, START, DATA, STOP.
  - IDLE: `TXD`=1. On a byte available, load the shift register, clear the bit counter and the baud counter, and go to START.
  - START: `TXD`=0 for `DIV` cycles, then go to DATA.
  - DATA: `TXD`=`shift[0]` for `DIV` cycles per bit. After each bit, shift right and increment the 3-bit bit counter. After bit 7 (counter wraps 7→0), go to STOP.
  - STOP: `TXD`=1 for `DIV` cycles. Then:
    - With the FIFO and FIFO non-empty: pop and go directly to START.
    - Otherwise: go to IDLE.
- Baud counter: counts 0..`DIV`-1 and wraps to 0 on the last cycle of each bit. Width is `$clog2(DIV)`.
- One frame is exactly 10×`DIV` cycles.
- `TXD` is registered; it never glitches between bits.
- `busy` = (state != IDLE) || (FIFO non-empty).
- Reset is asserted (`reset`=0) for at least one edge. It forces:
  - state = IDLE, `TXD`=1, `ready`=1, `busy`=0;
  - FIFO empty, all counters 0.
- Reset mid-frame aborts the frame immediately: `TXD` is high on the first cycle after the reset edge, and queued bytes are discarded.

## Timing

- Without FIFO:
  - `ready` = (state == IDLE).
  - Byte accepted at edge N → `TXD` falls at edge N+1 (start bit begins).
  - After STOP completes, the block spends one cycle in IDLE with `ready`=1. The minimum inter-frame gap is therefore 1 idle cycle when `valid` is held high.
- With FIFO:
  - `ready` = !full.
  - Push at edge N into an empty FIFO while IDLE → pop at N+1, `TXD` falls at N+2.
  - Back-to-back frames have zero idle cycles between stop and start.
- Simultaneous push and pop while full: not accepted. `ready` is 0 when full, regardless of a same-cycle pop.
- Simultaneous push and pop while non-full: both occur, and the count is unchanged.
- FIFO pointers are `$clog2(FIFO_DEPTH)` bits with an extra wrap bit; they wrap naturally. full = equal indices with different wrap bits.

## Configuration

- `UART_TX_FIFO_EN`:
  - Defined: instantiate the `FIFO_DEPTH`-entry FIFO between the handshake and the FSM, with timing as above.
  - Undefined: no FIFO; a single shift register is loaded directly on accept, and `FIFO_DEPTH` is ignored.

## Test plan

- Reset: hold `reset`=0 for 3 cycles → `TXD`=1, `ready`=1, `busy`=0. With `valid`=1 during reset, nothing is accepted.
- Single byte: `DIV`=4, send 0x55 → `TXD` = 0,1,0,1,0,1,0,1,0,1 (start, LSB first, stop), each level held 4 cycles. Total 40 cycles, then `busy`=0.
- Backpressure: no FIFO, `DIV`=4, `valid` held with 0xA5 then 0x3C → second byte accepted exactly 1 cycle after first stop ends. Both frames decode correctly.
- FIFO full: FIFO enabled, `DIV`=4, push 6 bytes 0x01..0x06 back-to-back →
  - `ready` drops after the 5th accept (1 in shift register + 4 queued);
  - all 6 frames emitted in order with zero idle gap.
- Reset mid-frame: start 0xFF, assert reset during bit 3 → `TXD`=1 the next cycle, FIFO empty. A new byte 0x00 afterwards yields a clean frame.
- Minimum divider: `DIV`=2, send 0x80 → bits 0–6 low and bit 7 high, each 2 cycles; frame is 20 cycles.
